uart_rx_oversampled: RTL
========================

# uart_rx_oversampled

Standalone UART receiver: deserialises an 8N1 (optionally 8E1/8O1) line into an AXI-Stream byte output with a one-entry holding register. Bit period is `prescale*8` clock cycles, with the start bit validated and every bit sampled mid-bit. The block receives the serial stream produced by the system `uart` transmitter (`txd`). It drives the same `m_axis_*` and error-flag contract the rest of the design already consumes.

## Interface
- `DATA_WIDTH`, 8, data bits per frame, LSB first.
- `PARITY_ODD`, 0. Selects the parity sense: 0 = even, 1 = odd. Only has an effect when `UART_RX_PARITY_EN` is defined.
- `clk` input 1: single clock; all logic is on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `prescale` input 16: bit period B = `prescale*8` cycles. It is captured at start detection. A value of 0 is treated as 1.
- `rxd` input 1: serial line, idle high, asynchronous to `clk`.
- `m_axis_tdata` output DATA_WIDTH: received byte.
- `m_axis_tvalid` output 1: byte available.
- `m_axis_tready` input 1: sink accepts.
- `rx_busy` output 1: a frame is in progress.
- `rx_overrun_error` output 1: one-cycle pulse.
- `rx_frame_error` output 1: one-cycle pulse.
- `rx_parity_error` output 1: one-cycle pulse. This port exists only when `UART_RX_PARITY_EN` is defined.

## Operation
- **Input synchroniser:** `rxd` passes through a 2-flop synchroniser (reset value 1) to give `rxd_s`. A further delayed copy `rxd_d` is kept for edge detection.
- **FSM states:** IDLE, START, DATA, [PARITY], STOP.
- **IDLE:**
  - A falling edge (`rxd_d`=1, `rxd_s`=0) at cycle t0 moves to START.
  - On that edge, latch B and load the bit counter with B/2-1.
- **START:**
  - Sample at counter==0, i.e. t0+B/2.
  - If the sample is 0: go to DATA, counter = B-1, bit index = 0.
  - If the sample is 1 (glitch): go to IDLE with no flags.
- **DATA:**
  - Data bit k is sampled at t0+B/2+(k+1)·B and shifted in LSB-first.
  - After bit DATA_WIDTH-1, go to [PARITY] or STOP.
- **STOP:** sampled at t0+B/2+(DATA_WIDTH+1)·B (+B if parity is enabled).
  - **Sample = 1 and `m_axis_tvalid`=0:** load `m_axis_tdata` and set `m_axis_tvalid` on the next cycle.
  - **Sample = 1 and `m_axis_tvalid`=1:**
    - The new byte is discarded; the held byte is kept.
    - `rx_overrun_error` pulses for one cycle.
  - **Sample = 0:** the byte is discarded and `rx_frame_error` pulses.
  - In every case the FSM returns to IDLE immediately. A new start bit can therefore be detected from mid-stop-bit onward.
- **AXI-Stream handshake:**
  - `m_axis_tvalid` is cleared on the cycle after `tvalid && tready`.
  - `tdata` is stable while `tvalid` is high.
- **Simultaneous events:** if `tvalid && tready` occurs on the same cycle as a good stop sample, this is not an overrun. The new byte is loaded and `tvalid` stays high.
- `rx_busy` = (state != IDLE).
- Counters and arithmetic:
  - B is 19 bits wide.
  - The bit counter is 19 bits, counts down, and reloads on each sample.
  - The bit index counter is 4 bits wide.

## Timing
- Reset values:
  - All outputs are 0: `m_axis_tdata`=0, `m_axis_tvalid`=0, `rx_busy`=0, and all error flags 0.
  - FSM in IDLE.
  - Synchroniser flops at 1.
- Latency: `m_axis_tvalid` rises at t0+B/2+9B+1 (8N1), where t0 is falling-edge detection, 2 cycles after the `rxd` edge.
- Error pulses are registered and assert on the cycle after the stop or parity sample.
- Reset asserted mid-frame:
  - The FSM, held byte, and flags clear immediately.
  - The partial frame is lost.
  - After release, a line already low is not treated as a start bit; only a falling edge starts a frame.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Adds the PARITY state, sampled B after the last data bit.
  - Parity is even or odd per `PARITY_ODD`.
  - On a mismatch, `rx_parity_error` pulses at the stop sample and the byte is discarded. This takes priority over overrun.
  - A frame error still takes precedence over a parity error.
- `UART_RX_PARITY_EN` undefined: no PARITY state, no `rx_parity_error` port, and the frame format is 8N1.

## Structure
- Package `uart_pkg`:
  - Enum `uart_rx_state_e`.
  - `UART_OVERSAMPLE` = 8.
  - `UART_BITCNT_W` = 19.
- Sub-module `uart_sync2`: generic 2-flop synchroniser with a reset value parameter, used for `rxd`.

## Test plan
- **Reset mid-frame:** `rst_n` low for 5 cycles during a frame of 0x68 (`prescale`=1).
  - All outputs are 0 while in reset.
  - The next frame, 0x65, is received correctly.
- **Nominal stream:** "hello world" at `prescale`=1 (B=8), random 0–49 cycle idle gaps, `tready`=1.
  - 11 bytes arrive in order.
  - `tvalid` rises 77 cycles after each t0.
- **Frame error:** 0x55 sent with the stop bit driven 0.
  - `rx_frame_error` pulses for exactly 1 cycle.
  - No `tvalid`.
- **Overrun:** `tready`=0; send 0x41 then 0x42.
  - `tdata` holds 0x41 and `rx_overrun_error` pulses once.
  - After `tready`=1, only 0x41 is delivered.
- **Glitch:** `rxd` low for 2 cycles at `prescale`=1.
  - `rx_busy` is high for 4 cycles, then low.
  - No byte and no flags.
- **Parity** (`UART_RX_PARITY_EN`, `PARITY_ODD`=0, `prescale`=3):
  - 0x07 with parity bit 1: delivered.
  - 0x07 with parity bit 0: `rx_parity_error` pulses and no `tvalid`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampled UART receiver.
// Optional parity support in the receiver is enabled with UART_RX_PARITY_EN.
package uart_pkg;

  localparam int unsigned UART_OVERSAMPLE = 8;
  localparam int unsigned UART_BITCNT_W   = 19;

  typedef logic [UART_BITCNT_W-1:0] bitcnt_t;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_rx_state_e;

  // Bit period in clock cycles; a prescale of 0 behaves as 1.
  function automatic bitcnt_t uart_bit_period(input logic [15:0] prescale);
    bitcnt_t p;
    p = (prescale == 16'd0) ? bitcnt_t'(1) : bitcnt_t'(prescale);
    return p * bitcnt_t'(UART_OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchroniser with a configurable reset value.
module uart_sync2 #(
  parameter logic ResetValue = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= ResetValue;
      sync_q <= ResetValue;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_oversampled.sv
// UART receiver (8N1, or 8E1/8O1 when UART_RX_PARITY_EN is defined) with mid-bit
// sampling and a one-entry AXI-Stream holding register.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           prescale,
  input  logic                  rxd,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  rx_busy,
  output logic                  rx_overrun_error,
`ifdef UART_RX_PARITY_EN
  output logic                  rx_frame_error,
  output logic                  rx_parity_error
`else
  output logic                  rx_frame_error
`endif
);

  uart_rx_state_e state_q, state_d;

  logic                  rxd_s;
  logic                  rxd_d_q;
  logic [1:0]            settle_q, settle_d;
  logic                  armed;
  logic                  start_edge;
  logic                  tick;
  logic                  last_bit;
  logic                  accept;
  bitcnt_t               bit_period;

  bitcnt_t               period_q, period_d;
  bitcnt_t               cnt_q, cnt_d;
  logic [3:0]            idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  par_bad_q, par_bad_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  ovr_q, ovr_d;
  logic                  ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                  perr_q, perr_d;
`endif

  uart_sync2 #(
    .ResetValue(1'b1)
  ) u_rxd_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (rxd),
    .q_o  (rxd_s)
  );

  // Edge detection stays disarmed until the reset values have flushed out of the
  // synchroniser and delay flop, so a line held low across reset is not a start bit.
  assign armed      = (settle_q == 2'd3);
  assign start_edge = armed && rxd_d_q && !rxd_s;
  assign tick       = (cnt_q == '0);
  assign last_bit   = (idx_q == 4'(DATA_WIDTH - 1));
  assign accept     = tvalid_q && m_axis_tready;
  assign bit_period = uart_bit_period(prescale);
  assign settle_d   = armed ? settle_q : settle_q + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_edge) state_d = StStart;
      StStart:  if (tick) state_d = rxd_s ? StIdle : StData;
      StData: begin
        if (tick && last_bit) begin
`ifdef UART_RX_PARITY_EN
          state_d = StParity;
`else
          state_d = StStop;
`endif
        end
      end
      StParity: if (tick) state_d = StStop;
      StStop:   if (tick) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    rx_busy          = (state_q != StIdle);
    m_axis_tdata     = tdata_q;
    m_axis_tvalid    = tvalid_q;
    rx_overrun_error = ovr_q;
    rx_frame_error   = ferr_q;
`ifdef UART_RX_PARITY_EN
    rx_parity_error  = perr_q;
`endif
  end

  always_comb begin
    period_d  = period_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    par_bad_d = par_bad_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    ovr_d     = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d    = 1'b0;
`endif

    if (accept) tvalid_d = 1'b0;

    if (state_q == StIdle) begin
      if (start_edge) begin
        period_d  = bit_period;
        cnt_d     = (bit_period >> 1) - bitcnt_t'(1);
        par_d     = PARITY_ODD;
        par_bad_d = 1'b0;
      end
    end else begin
      cnt_d = tick ? period_q - bitcnt_t'(1) : cnt_q - bitcnt_t'(1);
    end

    if (tick) begin
      unique case (state_q)
        StStart: idx_d = 4'd0;
        StData: begin
          shift_d = {rxd_s, shift_q[DATA_WIDTH-1:1]};
          par_d   = par_q ^ rxd_s;
          idx_d   = idx_q + 4'd1;
        end
        StParity: par_bad_d = par_q ^ rxd_s;
        StStop: begin
          // Priority: frame error, then parity error, then overrun.
          if (!rxd_s) begin
            ferr_d = 1'b1;
          end else if (par_bad_q) begin
`ifdef UART_RX_PARITY_EN
            perr_d = 1'b1;
`endif
          end else if (tvalid_q && !accept) begin
            ovr_d = 1'b1;
          end else begin
            tdata_d  = shift_q;
            tvalid_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_d_q   <= 1'b1;
      settle_q  <= 2'd0;
      period_q  <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      par_bad_q <= 1'b0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      rxd_d_q   <= rxd_s;
      settle_q  <= settle_d;
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      par_bad_q <= par_bad_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
`endif
    end
  end

endmodule
